crc_802_11_fcs_checker: RTL and testbench
=========================================

// Module: crc_802_11_fcs_checker
// PURPOSE
//  Receive-side FCS stage for the serial 802.11 MAC CRC path. Consumes a contiguous bit-serial
//  frame (payload MSB-first, then the 32 FCS bits), runs the same CRC-32 LFSR (init 32'hFFFFFFFF,
//  no final inversion) over every bit, and checks for a zero residue. It delays the stream by
//  32 valid bits so that only payload bits are forwarded and the FCS is stripped. At frame end
//  it reports pass/fail, payload length and a length error.
// PARAMETERS
//  CNT_W            16  width of the frame bit counter; saturates at 2**CNT_W-1
//  MIN_PAYLOAD_BITS  8  frames with fewer payload bits flag o_len_err
// PORTS
//  i_clk      in   1      clock; all logic is on the rising edge
//  i_rst      in   1      asynchronous, active-high reset
//  i_in_vld   in   1      frame bit valid; high for the whole frame, low for at least 1 cycle between frames
//  i_in       in   1      frame bit (payload then FCS, MSB-first)
//  o_out_vld  out  1      forwarded payload bit valid
//  o_out      out  1      forwarded payload bit
//  o_done     out  1      1-cycle pulse at frame end
//  o_fcs_ok   out  1      valid while o_done=1: residue==0 and no length error
//  o_len_err  out  1      valid while o_done=1: payload bits < MIN_PAYLOAD_BITS, or counter saturated
//  o_len      out  CNT_W  valid while o_done=1: payload bit count = accepted bits - 32 (0 if negative)
// BEHAVIOUR
//  - One clock domain, i_clk. Reset is asynchronous and active-high (i_rst).
//  - Reset values: all outputs 0. r_crc=32'hFFFFFFFF, delay line=0, counter=0, state=IDLE.
//  - FSM states:
//    - IDLE: on i_in_vld=1, go to RECV. This first bit is already accepted: CRC step from FFFFFFFF, count=1.
//    - RECV: on i_in_vld=1, accept the bit. On i_in_vld=0, go to IDLE and register the results.
//    - Gaps inside a frame are not supported: any low cycle ends the frame.
//  - CRC step, per accepted bit:
//    - fb = r_crc[31] ^ i_in
//    - r_crc = {r_crc[30:0],fb} ^ (fb ? (POLY & ~1) : 0), with POLY = 32'h04C11DB7
//    - r_crc reloads FFFFFFFF on every transition to IDLE.
//  - Delay line: 32-bit shift register r_dly, shifted in from the bit-0 end on each accepted bit.
//    - If the accepted bit index k >= 32 (count before the increment >= 32): o_out_vld<=1 and o_out<=r_dly[31].
//    - Otherwise o_out_vld<=0.
//    - Latency: payload bit n leaves in the cycle after input bit n+32 is accepted.
//    - o_out_vld is low in IDLE. The 32 FCS bits are never forwarded.
//  - Frame end: on the edge that samples i_in_vld=0 in RECV:
//    - o_done<=1.
//    - o_len<=cnt-32, clamped to 0.
//    - o_len_err<=(cnt < 32+MIN_PAYLOAD_BITS) | sat.
//    - o_fcs_ok<=(r_crc==0) & ~o_len_err_next.
//    - Next cycle: o_done<=0. o_fcs_ok, o_len_err and o_len hold until the next frame end.
//  - Back-to-back frames: the cycle in which o_done is high may carry the first bit of the next frame.
//    IDLE accepts it with a fresh CRC.
//  - Counter saturates at all-ones; sat stays set until IDLE. The CRC keeps running but o_fcs_ok=0.
//  - Reset mid-frame: all state is cleared immediately, no o_done is produced, and the partial frame is discarded.
//  - Counter arithmetic is unsigned CNT_W-bit. The 32-bit comparison uses CNT_W+1 bits, with no wrap.
// STRUCTURE
//  - Shared package crc_802_11_pkg holds:
//    - CRC32_POLY = 32'h04C11DB7, CRC32_INIT = 32'hFFFFFFFF, CRC32_RESIDUE = 32'h0, FCS_BITS = 32
//    - state enum {ST_IDLE, ST_RECV}
//  - Sub-module crc32_serial_step: combinational (crc_in, bit) -> crc_out, also reused by the generator.
//    The FSM, counter, delay line and result registers stay in this module.
// TESTING
//  1. Loopback: generator frame, payload 8'hA5 plus its FCS (40 bits)
//     -> o_done once; o_fcs_ok=1, o_len=8, o_len_err=0; o_out_vld for 8 cycles carrying 1,0,1,0,0,1,0,1.
//  2. Same frame with FCS bit 5 inverted -> o_fcs_ok=0, o_len_err=0, o_len=8; payload still forwarded.
//  3. 20-bit frame -> o_len=0, o_len_err=1, o_fcs_ok=0, o_out_vld never high.
//  4. Two good frames (payloads 8'hA5 and 16'h1234) separated by exactly 1 idle cycle
//     -> two o_done pulses, both o_fcs_ok=1, o_len=8 then 16.
//  5. i_rst pulsed after 20 bits of a 48-bit frame, then a clean 8'hA5 frame
//     -> outputs 0 during reset, no o_done for the aborted frame, then o_fcs_ok=1, o_len=8.
//  6. CNT_W=6, 70-bit frame -> o_len_err=1, o_fcs_ok=0.

Source files
------------

// File: rtl/crc_802_11_pkg.sv
// Shared constants and state type for the serial 802.11 CRC-32 generator/checker path.
package crc_802_11_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'h00000000;
   localparam int          FCS_BITS      = 32;

   typedef enum logic {
      ST_IDLE,
      ST_RECV
   } fcsState_e;

endpackage

// File: rtl/crc32_serial_step.sv
// One bit of the MSB-first CRC-32 LFSR; purely combinational so generator and checker share it.
module crc32_serial_step
   import crc_802_11_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic        bit_i,
   output logic [31:0] crc_o
);

   logic fb;

   assign fb    = crc_i[31] ^ bit_i;
   // The feedback bit lands in bit 0 directly, so the polynomial's bit 0 is masked off.
   assign crc_o = {crc_i[30:0], fb} ^ (fb ? (CRC32_POLY & ~32'h1) : 32'h0);

endmodule

// File: rtl/crc_802_11_fcs_checker.sv
// Receive-side FCS stage: checks the CRC residue, strips the 32 FCS bits and reports length.
module crc_802_11_fcs_checker
   import crc_802_11_pkg::*;
#(
   parameter int CNT_W            = 16,
   parameter int MIN_PAYLOAD_BITS = 8
)
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_vld,
   input  logic             i_in,
   output logic             o_out_vld,
   output logic             o_out,
   output logic             o_done,
   output logic             o_fcs_ok,
   output logic             o_len_err,
   output logic [CNT_W-1:0] o_len
);

   localparam int               CW1     = CNT_W + 1;
   localparam logic [CW1-1:0]   FCS_CMP = CW1'(FCS_BITS);
   localparam logic [CW1-1:0]   MIN_CMP = CW1'(FCS_BITS + MIN_PAYLOAD_BITS);
   localparam logic [CNT_W-1:0] FCS_SUB = CNT_W'(FCS_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   fcsState_e        state_q, state_d;
   logic [31:0]      crc_q, crc_d, crcNext;
   logic [31:0]      dly_q, dly_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             outVld_q, outVld_d;
   logic             out_q, out_d;
   logic             done_q, done_d;
   logic             fcsOk_q, fcsOk_d;
   logic             lenErr_q, lenErr_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CW1-1:0]   cntExt;
   logic             lenErrNext;

   crc32_serial_step u_step (
      .crc_i (crc_q),
      .bit_i (i_in),
      .crc_o (crcNext)
   );

   assign cntExt     = {1'b0, cnt_q};
   assign lenErrNext = (cntExt < MIN_CMP) | sat_q;

   // crc_q is always back at CRC32_INIT while idle, so the first bit can step from it directly.
   always_comb begin
      state_d  = state_q;
      crc_d    = crc_q;
      dly_d    = dly_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      outVld_d = 1'b0;
      out_d    = out_q;
      done_d   = 1'b0;
      fcsOk_d  = fcsOk_q;
      lenErr_d = lenErr_q;
      len_d    = len_q;
      case (state_q)
         ST_IDLE: begin
            if (i_in_vld) begin
               state_d = ST_RECV;
               crc_d   = crcNext;
               dly_d   = {dly_q[30:0], i_in};
               cnt_d   = CNT_W'(1);
               sat_d   = 1'b0;
            end
         end
         ST_RECV: begin
            if (i_in_vld) begin
               crc_d = crcNext;
               dly_d = {dly_q[30:0], i_in};
               if (cnt_q == CNT_MAX) begin
                  sat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (cntExt >= FCS_CMP) begin
                  outVld_d = 1'b1;
                  out_d    = dly_q[31];
               end
            end else begin
               state_d  = ST_IDLE;
               crc_d    = CRC32_INIT;
               cnt_d    = '0;
               sat_d    = 1'b0;
               done_d   = 1'b1;
               len_d    = (cntExt >= FCS_CMP) ? (cnt_q - FCS_SUB) : '0;
               lenErr_d = lenErrNext;
               fcsOk_d  = (crc_q == CRC32_RESIDUE) & ~lenErrNext;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         crc_q    <= CRC32_INIT;
         dly_q    <= '0;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         outVld_q <= 1'b0;
         out_q    <= 1'b0;
         done_q   <= 1'b0;
         fcsOk_q  <= 1'b0;
         lenErr_q <= 1'b0;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         crc_q    <= crc_d;
         dly_q    <= dly_d;
         cnt_q    <= cnt_d;
         sat_q    <= sat_d;
         outVld_q <= outVld_d;
         out_q    <= out_d;
         done_q   <= done_d;
         fcsOk_q  <= fcsOk_d;
         lenErr_q <= lenErr_d;
         len_q    <= len_d;
      end
   end

   assign o_out_vld = outVld_q;
   assign o_out     = out_q;
   assign o_done    = done_q;
   assign o_fcs_ok  = fcsOk_q;
   assign o_len_err = lenErr_q;
   assign o_len     = len_q;

endmodule

// File: tb/tb_crc_802_11_fcs_checker.sv
// Directed bench for the FCS checker: a default-width instance plus a CNT_W=6 instance for saturation.
module tb_crc_802_11_fcs_checker;

   localparam logic [31:0] GEN_POLY = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        rst;
   logic        inVld, inBit, inVldS, inBitS;
   logic        outVld, outBit, done, fcsOk, lenErr;
   logic [15:0] len;
   logic        outVldS, outBitS, doneS, fcsOkS, lenErrS;
   logic [5:0]  lenS;

   int compared   = 0;
   int mismatched = 0;

   bit          txQ[$];
   bit          outBits[$];
   logic [31:0] okQ[$], lenQ[$], errQ[$];
   logic [31:0] okSQ[$], lenSQ[$], errSQ[$];
   int          outVldSCount;

   crc_802_11_fcs_checker #(.CNT_W(16), .MIN_PAYLOAD_BITS(8)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_in_vld  (inVld),
      .i_in      (inBit),
      .o_out_vld (outVld),
      .o_out     (outBit),
      .o_done    (done),
      .o_fcs_ok  (fcsOk),
      .o_len_err (lenErr),
      .o_len     (len)
   );

   crc_802_11_fcs_checker #(.CNT_W(6), .MIN_PAYLOAD_BITS(8)) dutSmall (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_in_vld  (inVldS),
      .i_in      (inBitS),
      .o_out_vld (outVldS),
      .o_out     (outBitS),
      .o_done    (doneS),
      .o_fcs_ok  (fcsOkS),
      .o_len_err (lenErrS),
      .o_len     (lenS)
   );

   always #5 clk = ~clk;

   // Record every frame-end result and every forwarded bit, sampled mid-cycle.
   always @(negedge clk) begin
      if (done) begin
         okQ.push_back({31'b0, fcsOk});
         lenQ.push_back({16'b0, len});
         errQ.push_back({31'b0, lenErr});
      end
      if (outVld) outBits.push_back(outBit);
      if (doneS) begin
         okSQ.push_back({31'b0, fcsOkS});
         lenSQ.push_back({26'b0, lenS});
         errSQ.push_back({31'b0, lenErrS});
      end
      if (outVldS) outVldSCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [31:0] q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return 32'hDEADBEEF;
   endfunction

   // Payload MSB-first followed by its FCS, built with a shift-then-xor form of the CRC.
   task automatic buildFrame(input logic [63:0] pay, input int n, input logic [31:0] flip, input bit addFcs);
      logic [31:0] c;
      bit          b;
      txQ.delete();
      c = 32'hFFFFFFFF;
      for (int i = n - 1; i >= 0; i--) begin
         b = pay[i];
         txQ.push_back(b);
         if (c[31] ^ b) c = (c << 1) ^ GEN_POLY;
         else           c = c << 1;
      end
      if (addFcs) begin
         c = c ^ flip;
         for (int i = 31; i >= 0; i--) txQ.push_back(c[i]);
      end
   endtask

   task automatic applyStimulus(input bit useSmall);
      foreach (txQ[i]) begin
         if (useSmall) begin inVldS = 1'b1; inBitS = txQ[i]; end
         else          begin inVld  = 1'b1; inBit  = txQ[i]; end
         @(posedge clk); #1;
      end
      inVld  = 1'b0;
      inVldS = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic clearRecords();
      okQ.delete(); lenQ.delete(); errQ.delete(); outBits.delete();
      okSQ.delete(); lenSQ.delete(); errSQ.delete(); outVldSCount = 0;
   endtask

   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] packOut();
      logic [31:0] v = 32'h0;
      foreach (outBits[i]) v = {v[30:0], outBits[i]};
      return v;
   endfunction

   initial begin
      rst = 1'b1; inVld = 1'b0; inBit = 1'b0; inVldS = 1'b0; inBitS = 1'b0;
      outVldSCount = 0;
      @(negedge clk);
      checkOutput("reset_done",   {31'b0, done},   32'h0);
      checkOutput("reset_ok",     {31'b0, fcsOk},  32'h0);
      checkOutput("reset_lenerr", {31'b0, lenErr}, 32'h0);
      checkOutput("reset_len",    {16'b0, len},    32'h0);
      checkOutput("reset_outvld", {31'b0, outVld}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Test 1: good A5 frame
      clearRecords();
      buildFrame(64'hA5, 8, 32'h0, 1'b1);
      applyStimulus(1'b0);
      settle();
      checkOutput("t1_done_cnt", okQ.size(), 1);
      checkOutput("t1_ok",       pick(okQ, 0),  1);
      checkOutput("t1_len",      pick(lenQ, 0), 8);
      checkOutput("t1_lenerr",   pick(errQ, 0), 0);
      checkOutput("t1_out_cnt",  outBits.size(), 8);
      checkOutput("t1_out_bits", packOut(), 32'hA5);

      // Test 2: FCS bit 5 corrupted
      clearRecords();
      buildFrame(64'hA5, 8, 32'h0000_0020, 1'b1);
      applyStimulus(1'b0);
      settle();
      checkOutput("t2_done_cnt", okQ.size(), 1);
      checkOutput("t2_ok",       pick(okQ, 0),  0);
      checkOutput("t2_len",      pick(lenQ, 0), 8);
      checkOutput("t2_lenerr",   pick(errQ, 0), 0);
      checkOutput("t2_out_bits", packOut(), 32'hA5);

      // Test 3: 20-bit runt frame
      clearRecords();
      buildFrame(64'hABCDE, 20, 32'h0, 1'b0);
      applyStimulus(1'b0);
      settle();
      checkOutput("t3_done_cnt", okQ.size(), 1);
      checkOutput("t3_ok",       pick(okQ, 0),  0);
      checkOutput("t3_len",      pick(lenQ, 0), 0);
      checkOutput("t3_lenerr",   pick(errQ, 0), 1);
      checkOutput("t3_out_cnt",  outBits.size(), 0);

      // Test 4: back-to-back good frames with one idle cycle
      clearRecords();
      buildFrame(64'hA5, 8, 32'h0, 1'b1);
      applyStimulus(1'b0);
      buildFrame(64'h1234, 16, 32'h0, 1'b1);
      applyStimulus(1'b0);
      settle();
      checkOutput("t4_done_cnt", okQ.size(), 2);
      checkOutput("t4_ok0",      pick(okQ, 0),  1);
      checkOutput("t4_len0",     pick(lenQ, 0), 8);
      checkOutput("t4_ok1",      pick(okQ, 1),  1);
      checkOutput("t4_len1",     pick(lenQ, 1), 16);
      checkOutput("t4_out_bits", packOut(), 32'hA5_1234);

      // Test 5: reset after 20 bits of a 48-bit frame, then a clean frame
      clearRecords();
      buildFrame(64'hBEEF, 16, 32'h0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         inVld = 1'b1; inBit = txQ[i];
         @(posedge clk); #1;
      end
      rst = 1'b1; inVld = 1'b0;
      @(negedge clk);
      checkOutput("t5_rst_done",   {31'b0, done},   32'h0);
      checkOutput("t5_rst_ok",     {31'b0, fcsOk},  32'h0);
      checkOutput("t5_rst_len",    {16'b0, len},    32'h0);
      checkOutput("t5_rst_lenerr", {31'b0, lenErr}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      buildFrame(64'hA5, 8, 32'h0, 1'b1);
      applyStimulus(1'b0);
      settle();
      checkOutput("t5_done_cnt", okQ.size(), 1);
      checkOutput("t5_ok",       pick(okQ, 0),  1);
      checkOutput("t5_len",      pick(lenQ, 0), 8);
      checkOutput("t5_out_bits", packOut(), 32'hA5);

      // Test 6: narrow counter, good short frame then a 70-bit saturating frame
      clearRecords();
      buildFrame(64'hA5, 8, 32'h0, 1'b1);
      applyStimulus(1'b1);
      settle();
      checkOutput("t6a_done_cnt", okSQ.size(), 1);
      checkOutput("t6a_ok",       pick(okSQ, 0),  1);
      checkOutput("t6a_len",      pick(lenSQ, 0), 8);
      clearRecords();
      buildFrame(64'h2A_5A5A_5A5A, 38, 32'h0, 1'b1);
      applyStimulus(1'b1);
      settle();
      checkOutput("t6_done_cnt", okSQ.size(), 1);
      checkOutput("t6_ok",       pick(okSQ, 0),  0);
      checkOutput("t6_lenerr",   pick(errSQ, 0), 1);
      checkOutput("t6_len",      pick(lenSQ, 0), 31);
      checkOutput("t6_big_idle", okQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
